// File: rtl/data_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_bus_arbiter_pkg
// Description : Shared types and constants for the data-bus arbiter: FSM
//               state encoding, arbitration-mode selectors, bus field widths.
// Revision    : 1.0 - initial release
// ============================================================================
package data_bus_arbiter_pkg;

  // Memory-bus field widths
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  // Internal counter widths: latency 1..4, starvation limit 1..15
  localparam int LAT_W  = 3;
  localparam int CNT_W  = 4;

  // Arbitration mode selectors
  localparam int MODE_ROUND_ROBIN = 0;
  localparam int MODE_FIXED_PRIO  = 1;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage : data_bus_arbiter_pkg
`default_nettype wire

// File: rtl/data_bus_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module      : bus_arb_pick
// Description : Combinational winner select between two masters. Round-robin
//               grants the master not granted last; fixed priority grants M0
//               unless M1 has lost STARVE_LIMIT consecutive ties.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arb_pick
  import data_bus_arbiter_pkg::*;
#(
  parameter int PRIORITY_MODE = MODE_FIXED_PRIO,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic             req0,
  input  logic             req1,
  input  logic             last_grant,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             grant_valid,
  output logic             grant_owner
);

  // Pick a winner; a lone requester always wins, ties follow the mode
  always_comb begin
    grant_valid = req0 | req1;
    grant_owner = req1;
    if (req0 && req1) begin
      if (PRIORITY_MODE == MODE_ROUND_ROBIN) begin
        grant_owner = ~last_grant;
      end else begin
        grant_owner = (starve_cnt == CNT_W'(STARVE_LIMIT));
      end
    end
  end

endmodule : bus_arb_pick
`default_nettype wire

// File: rtl/data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_bus_arbiter
// Description : Two-master arbiter and sequencer for the data-memory bus.
//               Latches one request, drives the bus for the access latency
//               from registers, then pulses a one-cycle ack with read data
//               to the owning master.
// Revision    : 1.0 - initial release
// ============================================================================
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int READ_LATENCY  = 1,
  parameter int PRIORITY_MODE = MODE_FIXED_PRIO,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iM0Req,
  input  logic              iM0We,
  input  logic [BE_W-1:0]   iM0Be,
  input  logic [ADDR_W-1:0] iM0Addr,
  input  logic [DATA_W-1:0] iM0WData,
  output logic              oM0Ack,
  output logic [DATA_W-1:0] oM0RData,
  input  logic              iM1Req,
  input  logic              iM1We,
  input  logic [BE_W-1:0]   iM1Be,
  input  logic [ADDR_W-1:0] iM1Addr,
  input  logic [DATA_W-1:0] iM1WData,
  output logic              oM1Ack,
  output logic [DATA_W-1:0] oM1RData,
  output logic              oReadEnable,
  output logic              oWriteEnable,
  output logic [BE_W-1:0]   oByteEnable,
  output logic [ADDR_W-1:0] oAddress,
  output logic [DATA_W-1:0] oWriteData,
  input  logic [DATA_W-1:0] iReadData,
  output logic              oGrant
);

  state_t              state;
  state_t              state_nxt;
  logic                owner;
  logic                req_we;
  logic [LAT_W-1:0]    lat_cnt;
  logic [DATA_W-1:0]   rdata_q;
  logic [CNT_W-1:0]    starve_cnt;
  logic                bus_re;
  logic                bus_we;
  logic [BE_W-1:0]     bus_be;
  logic [ADDR_W-1:0]   bus_addr;
  logic [DATA_W-1:0]   bus_wdata;
  logic                grant_valid;
  logic                grant_owner;
  logic                sel_we;
  logic [BE_W-1:0]     sel_be;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                access_last;
  logic                grant_now;

  bus_arb_pick #(
    .PRIORITY_MODE (PRIORITY_MODE),
    .STARVE_LIMIT  (STARVE_LIMIT)
  ) u_pick (
    .req0        (iM0Req),
    .req1        (iM1Req),
    .last_grant  (owner),
    .starve_cnt  (starve_cnt),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // Attributes of the master that wins this round
  assign sel_we      = grant_owner ? iM1We    : iM0We;
  assign sel_be      = grant_owner ? iM1Be    : iM0Be;
  assign sel_addr    = grant_owner ? iM1Addr  : iM0Addr;
  assign sel_wdata   = grant_owner ? iM1WData : iM0WData;
  assign access_last = (lat_cnt == LAT_W'(1));
  assign grant_now   = (state == ST_IDLE) && grant_valid;

  // Bus outputs come straight from registers so they never glitch
  assign oReadEnable  = bus_re;
  assign oWriteEnable = bus_we;
  assign oByteEnable  = bus_be;
  assign oAddress     = bus_addr;
  assign oWriteData   = bus_wdata;
  assign oGrant       = owner;

  // State register; reset aborts any access in flight
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and ack/read-data outputs
  always_comb begin
    state_nxt = state;
    oM0Ack    = 1'b0;
    oM1Ack    = 1'b0;
    oM0RData  = '0;
    oM1RData  = '0;
    case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (access_last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        oM0Ack    = ~owner;
        oM1Ack    = owner;
        if (!req_we) begin
          oM0RData = owner ? '0 : rdata_q;
          oM1RData = owner ? rdata_q : '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, latency counter, bus drive and read-data capture
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      owner     <= 1'b1;
      req_we    <= 1'b0;
      lat_cnt   <= '0;
      rdata_q   <= '0;
      bus_re    <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            owner     <= grant_owner;
            req_we    <= sel_we;
            lat_cnt   <= sel_we ? LAT_W'(1) : LAT_W'(READ_LATENCY);
            bus_re    <= ~sel_we;
            bus_we    <= sel_we;
            bus_be    <= sel_be;
            bus_addr  <= sel_addr;
            bus_wdata <= sel_wdata;
          end
        end
        ST_ACCESS: begin
          lat_cnt <= lat_cnt - LAT_W'(1);
          if (access_last) begin
            if (!req_we) begin
              rdata_q <= iReadData;
            end
            bus_re    <= 1'b0;
            bus_we    <= 1'b0;
            bus_be    <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  if (PRIORITY_MODE == MODE_FIXED_PRIO) begin : g_starve
    // Count ties M1 loses; an M1 grant clears the count
    always_ff @(posedge iCLK) begin
      if (!iRST_n) begin
        starve_cnt <= '0;
      end else if (grant_now) begin
        if (grant_owner) begin
          starve_cnt <= '0;
        end else if (iM1Req && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
          starve_cnt <= starve_cnt + CNT_W'(1);
        end
      end
    end
  end else begin : g_no_starve
    assign starve_cnt = '0;
  end

endmodule : data_bus_arbiter
`default_nettype wire

// File: tb/tb_data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_bus_arbiter
// Description : Scoreboard bench. Instance 0: READ_LATENCY 2, fixed priority,
//               STARVE_LIMIT 2. Instance 1: READ_LATENCY 1, round-robin.
//               Drivers replay per-master command tables; monitors pop the
//               expected acks and bus cycles whenever the DUT shows them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_bus_arbiter;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
  } cmd_t;

  typedef struct {
    int          inst;
    int          m;
    logic [31:0] rd;
    int          cyc;
  } ack_t;

  typedef struct {
    int          inst;
    logic        re;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    int          cyc;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst_n  [2];
  logic        req    [2][2];
  logic        wen    [2][2];
  logic [3:0]  be     [2][2];
  logic [31:0] addr   [2][2];
  logic [31:0] wdata  [2][2];
  logic        ack    [2][2];
  logic [31:0] rdata  [2][2];
  logic        re_o   [2];
  logic        we_o   [2];
  logic [3:0]  be_o   [2];
  logic [31:0] addr_o [2];
  logic [31:0] wd_o   [2];
  logic [31:0] rd_i   [2];
  logic        grant  [2];

  cmd_t tbl [4][16];
  int   head [4];
  int   tail [4];
  ack_t ackq [$];
  bus_t busq [$];
  int   cyc = 0;
  int   n_vec;
  int   n_bad;
  int   t0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h9000_0000) return 32'h1234_5678;
    return a ^ 32'h5A5A_5A5A;
  endfunction

  data_bus_arbiter #(.READ_LATENCY(2), .PRIORITY_MODE(1), .STARVE_LIMIT(2)) u_dut_fp (
    .iCLK(clk), .iRST_n(rst_n[0]),
    .iM0Req(req[0][0]), .iM0We(wen[0][0]), .iM0Be(be[0][0]), .iM0Addr(addr[0][0]),
    .iM0WData(wdata[0][0]), .oM0Ack(ack[0][0]), .oM0RData(rdata[0][0]),
    .iM1Req(req[0][1]), .iM1We(wen[0][1]), .iM1Be(be[0][1]), .iM1Addr(addr[0][1]),
    .iM1WData(wdata[0][1]), .oM1Ack(ack[0][1]), .oM1RData(rdata[0][1]),
    .oReadEnable(re_o[0]), .oWriteEnable(we_o[0]), .oByteEnable(be_o[0]),
    .oAddress(addr_o[0]), .oWriteData(wd_o[0]), .iReadData(rd_i[0]), .oGrant(grant[0])
  );

  data_bus_arbiter #(.READ_LATENCY(1), .PRIORITY_MODE(0), .STARVE_LIMIT(4)) u_dut_rr (
    .iCLK(clk), .iRST_n(rst_n[1]),
    .iM0Req(req[1][0]), .iM0We(wen[1][0]), .iM0Be(be[1][0]), .iM0Addr(addr[1][0]),
    .iM0WData(wdata[1][0]), .oM0Ack(ack[1][0]), .oM0RData(rdata[1][0]),
    .iM1Req(req[1][1]), .iM1We(wen[1][1]), .iM1Be(be[1][1]), .iM1Addr(addr[1][1]),
    .iM1WData(wdata[1][1]), .oM1Ack(ack[1][1]), .oM1RData(rdata[1][1]),
    .oReadEnable(re_o[1]), .oWriteEnable(we_o[1]), .oByteEnable(be_o[1]),
    .oAddress(addr_o[1]), .oWriteData(wd_o[1]), .iReadData(rd_i[1]), .oGrant(grant[1])
  );

  for (genvar gd = 0; gd < 2; gd++) begin : g_mem
    assign rd_i[gd] = re_o[gd] ? mem_model(addr_o[gd]) : 32'h0;
  end

  // Master drivers: hold req until ack, then chain the next command or drop
  for (genvar gk = 0; gk < 4; gk++) begin : g_drv
    localparam int D = gk / 2;
    localparam int M = gk % 2;
    initial begin
      forever begin
        @(negedge clk);
        if (req[D][M]) begin
          if (ack[D][M]) begin
            if (head[gk] < tail[gk]) begin
              wen[D][M]   = tbl[gk][head[gk]].we;
              be[D][M]    = tbl[gk][head[gk]].be;
              addr[D][M]  = tbl[gk][head[gk]].addr;
              wdata[D][M] = tbl[gk][head[gk]].wd;
              head[gk]++;
            end else begin
              req[D][M] = 1'b0;
            end
          end
        end else if (rst_n[D] && (head[gk] < tail[gk])) begin
          wen[D][M]   = tbl[gk][head[gk]].we;
          be[D][M]    = tbl[gk][head[gk]].be;
          addr[D][M]  = tbl[gk][head[gk]].addr;
          wdata[D][M] = tbl[gk][head[gk]].wd;
          head[gk]++;
          req[D][M] = 1'b1;
        end
      end
    end
  end

  task automatic check_ack(input int d, input int m);
    int   idx;
    ack_t e;
    idx = -1;
    foreach (ackq[i]) if (idx < 0 && ackq[i].inst == d) idx = i;
    n_vec++;
    if (idx < 0) begin
      n_bad++;
      $display("FAIL ack_unexpected inst=%0d cycle=%0d actual ack on M%0d required no ack", d, cyc, m);
    end else begin
      e = ackq[idx];
      ackq.delete(idx);
      if (e.m != m || e.cyc != cyc || rdata[d][m] !== e.rd || grant[d] !== (m == 1) ||
          ack[d][1-m] !== 1'b0 || rdata[d][1-m] !== 32'h0) begin
        n_bad++;
        $display("FAIL ack inst=%0d actual M%0d cyc=%0d rdata=%h grant=%b other_ack=%b other_rdata=%h required M%0d cyc=%0d rdata=%h",
                 d, m, cyc, rdata[d][m], grant[d], ack[d][1-m], rdata[d][1-m], e.m, e.cyc, e.rd);
      end
    end
  endtask

  task automatic check_bus(input int d);
    int   idx;
    bus_t e;
    idx = -1;
    foreach (busq[i]) if (idx < 0 && busq[i].inst == d) idx = i;
    n_vec++;
    if (idx < 0) begin
      n_bad++;
      $display("FAIL bus_unexpected inst=%0d cycle=%0d actual re=%b we=%b addr=%h required bus idle",
               d, cyc, re_o[d], we_o[d], addr_o[d]);
    end else begin
      e = busq[idx];
      busq.delete(idx);
      if (e.cyc != cyc || re_o[d] !== e.re || we_o[d] !== e.we || addr_o[d] !== e.addr ||
          be_o[d] !== e.be || wd_o[d] !== e.wd) begin
        n_bad++;
        $display("FAIL bus inst=%0d actual cyc=%0d re=%b we=%b addr=%h be=%h wd=%h required cyc=%0d re=%b we=%b addr=%h be=%h wd=%h",
                 d, cyc, re_o[d], we_o[d], addr_o[d], be_o[d], wd_o[d], e.cyc, e.re, e.we, e.addr, e.be, e.wd);
      end
    end
  endtask

  // Monitors: compare whatever the DUT presents against the scoreboard
  for (genvar gd = 0; gd < 2; gd++) begin : g_mon
    initial begin
      forever begin
        @(negedge clk);
        for (int m = 0; m < 2; m++) if (ack[gd][m]) check_ack(gd, m);
        if (re_o[gd] || we_o[gd]) check_bus(gd);
      end
    end
  end

  task automatic push_cmd(input int d, input int m, input logic w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] wd);
    int k;
    k = d * 2 + m;
    tbl[k][tail[k]] = '{we: w, be: b, addr: a, wd: wd};
    tail[k]++;
  endtask

  task automatic exp_wr(input int d, input int m, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] wd, input int bus_cyc);
    busq.push_back('{inst: d, re: 1'b0, we: 1'b1, be: b, addr: a, wd: wd, cyc: bus_cyc});
    ackq.push_back('{inst: d, m: m, rd: 32'h0, cyc: bus_cyc + 1});
  endtask

  task automatic exp_rd(input int d, input int m, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] rd, input int bus_cyc, input int lat);
    for (int i = 0; i < lat; i++)
      busq.push_back('{inst: d, re: 1'b1, we: 1'b0, be: b, addr: a, wd: 32'h0, cyc: bus_cyc + i});
    ackq.push_back('{inst: d, m: m, rd: rd, cyc: bus_cyc + lat});
  endtask

  task automatic check_reset(input int d, input string name);
    n_vec++;
    if (re_o[d] !== 1'b0 || we_o[d] !== 1'b0 || be_o[d] !== 4'h0 || addr_o[d] !== 32'h0 ||
        wd_o[d] !== 32'h0 || ack[d][0] !== 1'b0 || ack[d][1] !== 1'b0 ||
        rdata[d][0] !== 32'h0 || rdata[d][1] !== 32'h0 || grant[d] !== 1'b1) begin
      n_bad++;
      $display("FAIL %s inst=%0d actual re=%b we=%b be=%h addr=%h wd=%h ack=%b%b rd0=%h rd1=%h grant=%b required all 0 and grant=1",
               name, d, re_o[d], we_o[d], be_o[d], addr_o[d], wd_o[d], ack[d][0], ack[d][1],
               rdata[d][0], rdata[d][1], grant[d]);
    end
  endtask

  task automatic wait_drain(input int d, input string name);
    bool_loop: begin
      int  left;
      bit  busy;
      left = 200;
      busy = 1'b1;
      while (busy && left > 0) begin
        @(posedge clk);
        left--;
        busy = 1'b0;
        foreach (ackq[i]) if (ackq[i].inst == d) busy = 1'b1;
      end
      n_vec++;
      if (busy) begin
        n_bad++;
        $display("FAIL %s_timeout inst=%0d actual acks still pending required all acks within 200 cycles", name, d);
      end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic start_phase();
    @(posedge clk);
    #1;
    t0 = cyc;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual simulation still running required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    for (int k = 0; k < 4; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      for (int m = 0; m < 2; m++) begin
        req[d][m] = 1'b0; wen[d][m] = 1'b0; be[d][m] = 4'h0;
        addr[d][m] = 32'h0; wdata[d][m] = 32'h0;
      end
    end
    repeat (3) @(negedge clk);
    check_reset(0, "reset");
    check_reset(1, "reset");
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Round-robin contention from reset: M0, M1, M0, M1
    start_phase();
    push_cmd(1, 0, 1'b1, 4'hF, 32'h2000_0000, 32'hA0A0_0001);
    push_cmd(1, 0, 1'b1, 4'hF, 32'h2000_0004, 32'hA0A0_0002);
    push_cmd(1, 1, 1'b1, 4'hF, 32'h3000_0000, 32'hB0B0_0001);
    push_cmd(1, 1, 1'b1, 4'hF, 32'h3000_0004, 32'hB0B0_0002);
    exp_wr(1, 0, 32'h2000_0000, 4'hF, 32'hA0A0_0001, t0 + 1);
    exp_wr(1, 1, 32'h3000_0000, 4'hF, 32'hB0B0_0001, t0 + 4);
    exp_wr(1, 0, 32'h2000_0004, 4'hF, 32'hA0A0_0002, t0 + 7);
    exp_wr(1, 1, 32'h3000_0004, 4'hF, 32'hB0B0_0002, t0 + 10);
    wait_drain(1, "rr_contention");

    // Single-cycle read on the round-robin instance
    start_phase();
    push_cmd(1, 1, 1'b0, 4'hF, 32'h9000_0000, 32'h0);
    exp_rd(1, 1, 32'h9000_0000, 4'hF, 32'h1234_5678, t0 + 1, 1);
    wait_drain(1, "rr_read");

    // Single M0 write
    start_phase();
    push_cmd(0, 0, 1'b1, 4'hF, 32'h1001_0004, 32'hDEAD_BEEF);
    exp_wr(0, 0, 32'h1001_0004, 4'hF, 32'hDEAD_BEEF, t0 + 1);
    wait_drain(0, "m0_write");

    // M1 read, two-cycle latency
    start_phase();
    push_cmd(0, 1, 1'b0, 4'hF, 32'h9000_0000, 32'h0);
    exp_rd(0, 1, 32'h9000_0000, 4'hF, 32'h1234_5678, t0 + 1, 2);
    wait_drain(0, "m1_read");

    // M0 read with partial byte enables, pass-through data
    start_phase();
    push_cmd(0, 0, 1'b0, 4'hC, 32'h1001_0004, 32'h0);
    exp_rd(0, 0, 32'h1001_0004, 4'hC, 32'h4A5B_5A5E, t0 + 1, 2);
    wait_drain(0, "m0_read");

    // Fixed priority, starve limit 2: M0, M0, M1, M0, M0, M1
    start_phase();
    for (int i = 0; i < 4; i++)
      push_cmd(0, 0, 1'b1, 4'hF, 32'h4000_0000 + 32'(i * 4), 32'hC0C0_0000 + 32'(i));
    push_cmd(0, 1, 1'b1, 4'hF, 32'h5000_0000, 32'hD0D0_0000);
    push_cmd(0, 1, 1'b1, 4'hF, 32'h5000_0004, 32'hD0D0_0001);
    exp_wr(0, 0, 32'h4000_0000, 4'hF, 32'hC0C0_0000, t0 + 1);
    exp_wr(0, 0, 32'h4000_0004, 4'hF, 32'hC0C0_0001, t0 + 4);
    exp_wr(0, 1, 32'h5000_0000, 4'hF, 32'hD0D0_0000, t0 + 7);
    exp_wr(0, 0, 32'h4000_0008, 4'hF, 32'hC0C0_0002, t0 + 10);
    exp_wr(0, 0, 32'h4000_000C, 4'hF, 32'hC0C0_0003, t0 + 13);
    exp_wr(0, 1, 32'h5000_0004, 4'hF, 32'hD0D0_0001, t0 + 16);
    wait_drain(0, "fp_contention");

    // Back-to-back writes: second ack three cycles after the first
    start_phase();
    push_cmd(0, 0, 1'b1, 4'hF, 32'h1001_0004, 32'hCAFE_F00D);
    push_cmd(0, 0, 1'b1, 4'h1, 32'h1001_0008, 32'h0000_0001);
    exp_wr(0, 0, 32'h1001_0004, 4'hF, 32'hCAFE_F00D, t0 + 1);
    exp_wr(0, 0, 32'h1001_0008, 4'h1, 32'h0000_0001, t0 + 4);
    wait_drain(0, "back_to_back");

    // Reset during the first ACCESS cycle of an M0 read: aborted, no ack
    start_phase();
    push_cmd(0, 0, 1'b0, 4'hF, 32'h1001_0008, 32'h0);
    busq.push_back('{inst: 0, re: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h1001_0008, wd: 32'h0, cyc: t0 + 1});
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (re_o[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_pre inst=0 actual re=%b required re=1", re_o[0]);
    end
    rst_n[0] = 1'b0;
    req[0][0] = 1'b0;
    @(negedge clk);
    n_vec++;
    if (re_o[0] !== 1'b0 || we_o[0] !== 1'b0 || ack[0][0] !== 1'b0 || ack[0][1] !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_idle inst=0 actual re=%b we=%b ack=%b%b required all 0",
               re_o[0], we_o[0], ack[0][0], ack[0][1]);
    end
    @(negedge clk);
    check_reset(0, "abort_reset");
    rst_n[0] = 1'b1;
    repeat (4) @(negedge clk);

    // Normal service after reset release
    start_phase();
    push_cmd(0, 0, 1'b1, 4'h6, 32'h1001_0010, 32'h0BAD_F00D);
    exp_wr(0, 0, 32'h1001_0010, 4'h6, 32'h0BAD_F00D, t0 + 1);
    wait_drain(0, "post_reset");

    repeat (4) @(posedge clk);
    n_vec++;
    if (ackq.size() != 0) begin
      n_bad++;
      $display("FAIL ack_leftover actual %0d pending required 0", ackq.size());
    end
    n_vec++;
    if (busq.size() != 0) begin
      n_bad++;
      $display("FAIL bus_leftover actual %0d pending required 0", busq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_data_bus_arbiter
`default_nettype wire
